// File: rtl/store_encoder_if.sv
// Store encoder bus bundle: request side (execute stage) plus memory write port.
// master = the requester/memory environment, slave = the store encoder.
interface store_encoder_if #(
    parameter int unsigned ADDR_W = 32
) ();
    // Request side
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic              sb;
    logic              sh;
    logic              sw;
    // Memory write port
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_we;
    // Status pulses
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_addr, req_data, sb, sh, sw, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_we, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, sb, sh, sw, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_we, done, err
    );
endinterface

// File: rtl/store_encoder.sv
// Store encoder: turns a right-justified store request into word-aligned write beats
// with lane-shifted data and byte enables.
// Optional macro MISALIGN_SPLIT_EN: accept misaligned stores, splitting word-crossing
// ones into two beats. Without it, misaligned sh/sw are rejected with an err pulse.
module store_encoder #(
    parameter int unsigned ADDR_W = 32
) (
    input logic            clk,
    input logic            rst_n,
    store_encoder_if.slave bus
);

`ifdef MISALIGN_SPLIT_EN
    // Two words of lanes so a crossing store can be shifted in one go.
    localparam int unsigned Lanes = 8;
`else
    localparam int unsigned Lanes = 4;
`endif

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBeat0 = 2'd1;
`ifdef MISALIGN_SPLIT_EN
    localparam logic [1:0] StBeat1 = 2'd2;
`endif

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [8*Lanes-1:0] data_q, data_d;
    logic [Lanes-1:0]   we_q, we_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [1:0]         off;
    logic [3:0]         size_mask;
    logic               onehot;
    logic               legal;
    logic [31:0]        data_masked;
    logic [Lanes-1:0]   we_ext, we_shift;
    logic [8*Lanes-1:0] data_ext, data_shift;

    // Decode the request: size, legality, and lane-positioned data/enables.
    always_comb begin
        off       = bus.req_addr[1:0];
        onehot    = 1'b0;
        size_mask = 4'b0000;
        case ({bus.sb, bus.sh, bus.sw})
            3'b100:  begin onehot = 1'b1; size_mask = 4'b0001; end
            3'b010:  begin onehot = 1'b1; size_mask = 4'b0011; end
            3'b001:  begin onehot = 1'b1; size_mask = 4'b1111; end
            default: begin onehot = 1'b0; size_mask = 4'b0000; end
        endcase
`ifdef MISALIGN_SPLIT_EN
        legal = onehot;
`else
        legal = onehot && !(bus.sh && off[0]) && !(bus.sw && (off != 2'b00));
`endif
        // Drop data bits beyond the store size so unused lanes stay zero.
        data_masked = bus.req_data & {{8{size_mask[3]}}, {8{size_mask[2]}},
                                      {8{size_mask[1]}}, {8{size_mask[0]}}};
        we_ext        = '0;
        we_ext[3:0]   = size_mask;
        we_shift      = we_ext << off;
        data_ext      = '0;
        data_ext[31:0] = data_masked;
        data_shift    = data_ext << {off, 3'b000};
    end

    // Next-state: capture on accept, advance beats on memory handshake.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (legal) begin
                        state_d = StBeat0;
                        addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        data_d  = data_shift;
                        we_d    = we_shift;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StBeat0: begin
                if (bus.mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
                    if (|we_q[7:4]) begin
                        state_d = StBeat1;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
`else
                    state_d = StIdle;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            StBeat1: begin
                if (bus.mem_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any in-flight store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs: beat fields are zero whenever no beat is presented.
    always_comb begin
        bus.req_ready = rst_n && (state_q == StIdle);
        bus.mem_valid = (state_q != StIdle);
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = '0;
        if (state_q == StBeat0) begin
            bus.mem_addr  = addr_q;
            bus.mem_wdata = data_q[31:0];
            bus.mem_we    = we_q[3:0];
        end
`ifdef MISALIGN_SPLIT_EN
        if (state_q == StBeat1) begin
            bus.mem_addr  = addr_q + ADDR_W'(4);
            bus.mem_wdata = data_q[63:32];
            bus.mem_we    = we_q[7:4];
        end
`endif
        bus.done = done_q;
        bus.err  = err_q;
    end

endmodule

// File: doc/store_encoder.md
Name: store_encoder

Overview:
- Store-side counterpart of the load-path data decoder.
- Accepts one store request at a time (address, register data, one-hot size select) over a valid/ready handshake.
- Produces a word-aligned memory write beat: lane-shifted write data plus a 4-bit byte write-enable.
- With the optional feature compiled in, splits word-crossing stores into two beats.
- Sits between the execute stage and the data-memory write port.

Parameters:
ADDR_W, 32, width of request and memory addresses (memory word = 32 bits, byte-addressed)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  store request valid
req_ready  output  1  block can accept a request
req_addr  input  ADDR_W  byte address of the store
req_data  input  32  store data, right-justified
sb  input  1  store byte
sh  input  1  store halfword
sw  input  1  store word
mem_valid  output  1  write beat valid
mem_ready  input  1  memory accepts the beat
mem_addr  output  ADDR_W  word-aligned write address; bits [1:0] always 0
mem_wdata  output  32  lane-positioned write data
mem_we  output  4  byte write-enable; bit i enables bits [8i+7:8i]
done  output  1  one-cycle pulse when the final beat of a store is accepted
err  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - req_ready=1 once reset is released.
  - mem_valid, mem_addr, mem_wdata, mem_we, done and err are all 0.
  - Reset mid-beat aborts the store; no partial retry after reset.
- FSM states:
  - IDLE: req_ready=1, mem_valid=0.
  - BEAT0: first or only beat; req_ready=0.
  - BEAT1: second beat of a split store; req_ready=0.
- Accept: req_valid && req_ready at edge N.
  - Request is captured into registers.
  - Capture uses off=req_addr[1:0] and size: sb→1 byte, sh→2 bytes, sw→4 bytes.
- Invalid op: {sb,sh,sw} not one-hot.
  - err=1 in cycle N+1; no beat issued; state stays IDLE.
- Misalignment without MISALIGN_SPLIT_EN:
  - The request is rejected (err pulse, no beat) if sh has off[0]=1, or sw has off≠0.
- Legal single-beat request:
  - BEAT0 entered; mem_valid=1 from cycle N+1.
  - mem_addr = {req_addr[ADDR_W-1:2],2'b00}.
  - mem_we = (size mask 0001/0011/1111) << off.
  - mem_wdata = right-justified data << 8*off.
  - mem_wdata lanes with we=0 are driven 0.
- Handshake rules:
  - mem_addr, mem_wdata and mem_we hold stable while mem_valid && !mem_ready.
  - mem_valid never drops before mem_ready.
  - A beat completes on the edge where mem_valid && mem_ready.
- Completion of the final beat:
  - Return to IDLE; done=1 for the following cycle.
  - req_ready=1 that same cycle.
  - Throughput is at most one single-beat store per 2 cycles when mem_ready is held high.
- mem_ready while mem_valid=0 is ignored.
- done and err never assert together.
- Width rules: only the low 8/16 bits of req_data are used for sb/sh; upper bits are ignored.

Optional Feature:
- Macro: MISALIGN_SPLIT_EN.
- Defined:
  - Non-naturally-aligned stores that fit within one word are issued as a single beat (e.g. sh at off=1 → we=0110).
  - Word-crossing stores (sh at off=3; sw at off=1..3) are split into two beats.
- Split store, beat 0 (BEAT0):
  - mem_addr = aligned addr.
  - mem_we = (size mask << off)[3:0].
  - data is the low bytes of the store.
- Split store, beat 1 (BEAT1):
  - mem_addr = aligned addr + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC → 0x00000000).
  - mem_we = (size mask << off)[7:4].
  - data is the remaining bytes placed from lane 0.
- done pulses only after the BEAT1 handshake; no done after BEAT0.
- Undefined: the misalignment rejection rule above applies; the BEAT1 state and its logic are absent.

Test Plan:
- Reset/idle:
  - Assert rst_n=0 during BEAT0 with mem_valid=1 → all outputs 0 immediately (asynchronously).
  - After release: req_ready=1, no beat issued.
- Store byte, stalled memory:
  - Inputs: sb, addr=0x00001002, data=0xDEADBEEF; mem_ready low 3 cycles.
  - Required: mem_addr=0x00001000, we=0100, wdata=0x00EF0000, all held 3 cycles.
  - Then: done pulse one cycle after the handshake.
- Store halfword:
  - Inputs: sh, addr=0x20, data=0x1234ABCD.
  - Required: mem_addr=0x20, we=0011, wdata=0x0000ABCD; next request accepted the cycle after done.
- Invalid op and misalignment:
  - sb=sh=1 → err pulse, mem_valid stays 0.
  - Macro off, sw addr=0x41 → err, no beat.
- Split store, word (MISALIGN_SPLIT_EN):
  - Inputs: sw, addr=0x103, data=0xAABBCCDD.
  - Beat0: addr=0x100, we=1000, wdata=0xDD000000.
  - Beat1: addr=0x104, we=0111, wdata=0x00AABBCC.
  - Single done pulse.
- Split store, wrap (MISALIGN_SPLIT_EN):
  - Inputs: sh, addr=0xFFFFFFFF, data=0x5566.
  - Beat0: addr=0xFFFFFFFC, we=1000, wdata=0x66000000.
  - Beat1: addr=0x00000000, we=0001, wdata=0x00000055.
